// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad front end: column scan, row sync, press/release debounce.
// Emits one key_valid pulse per accepted press; key_held spans press to release.
module keypad_scan_debounce #(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CYC = 540000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] columnas,
    input  logic [3:0] filas,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t        state;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] deb_cnt;
    logic [1:0]    low_row;
    logic          any_low;
    logic          row_low;

    function automatic logic [3:0] key_map(input logic [1:0] r,
                                           input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        unique case ({r, c})
            4'b0000: code = 4'h1;
            4'b0001: code = 4'h2;
            4'b0010: code = 4'h3;
            4'b0011: code = 4'hA;
            4'b0100: code = 4'h4;
            4'b0101: code = 4'h5;
            4'b0110: code = 4'h6;
            4'b0111: code = 4'hB;
            4'b1000: code = 4'h7;
            4'b1001: code = 4'h8;
            4'b1010: code = 4'h9;
            4'b1011: code = 4'hC;
            4'b1100: code = 4'hE;
            4'b1101: code = 4'h0;
            4'b1110: code = 4'hF;
            4'b1111: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Lowest-index low row wins when several rows are closed.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) low_row = 2'(i);
        end
    end

    assign any_low = ~&rows_s;
    assign row_low = ~rows_s[row_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            rows_m    <= 4'b1111;
            rows_s    <= 4'b1111;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            columnas  <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rows_m    <= filas;
            rows_s    <= rows_m;
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        if (any_low) begin
                            row_idx <= low_row;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            scan_cnt <= '0;
                            col_idx  <= col_idx + 2'd1;
                            columnas <= {columnas[2:0], columnas[3]};
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_low) begin
                        if (deb_cnt == DEB_LAST) begin
                            key_code  <= key_map(row_idx, col_idx);
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= PRESSED;
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
                    end else begin
                        // Glitch: abandon and move on to the next column.
                        state    <= SCAN;
                        scan_cnt <= '0;
                        col_idx  <= col_idx + 2'd1;
                        columnas <= {columnas[2:0], columnas[3]};
                    end
                end
                PRESSED: begin
                    if (!row_low) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_low) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        state    <= SCAN;
                        scan_cnt <= '0;
                        col_idx  <= col_idx + 2'd1;
                        columnas <= {columnas[2:0], columnas[3]};
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad matrix model plus event scoreboard.
// Expected key codes are queued at press time and popped on key_valid.
module tb_keypad_scan_debounce;

    logic       clk;
    logic       rst;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    logic        prev_valid;
    int          n_checks;
    int          n_errors;

    keypad_scan_debounce #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .columnas(columnas),
        .filas(filas),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key (r,c) is bit r*4+c; a closed key pulls its row low when its column is driven.
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    always @(negedge clk) begin
        if (key_valid) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            check("held_on_valid", {31'd0, key_held}, 32'd1);
            if (exp_q.size() == 0)
                check("spurious_pulse", {28'd0, key_code}, 32'hFFFF);
            else
                check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
        end
        prev_valid = key_valid;
    end

    task automatic wait_col(input int c);
        int n;
        logic [3:0] prev;
        n = 0;
        prev = columnas;
        @(negedge clk);
        while (!(columnas == col_drive(c) && prev != columnas) && n < 64) begin
            prev = columnas;
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("wait_col_timeout", n, 0);
    endtask

    task automatic wait_held(input logic v);
        int n;
        n = 0;
        while (key_held !== v && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("wait_held_timeout", {31'd0, key_held}, {31'd0, v});
    endtask

    task automatic press_key(input int r, input int c, input int hold,
                             input logic [3:0] code);
        wait_col(c);
        keys[r*4+c] = 1'b1;
        exp_q.push_back(code);
        repeat (hold) @(negedge clk);
        keys = '0;
        wait_held(1'b0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        prev_valid = 1'b0;
        keys       = '0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_columnas", {28'd0, columnas}, 32'hE);
        check("rst_key_code", {28'd0, key_code}, 32'h0);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_held", {31'd0, key_held}, 32'd0);

        // Idle scan: column rotates every 4 cycles.
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("scan_col", {28'd0, columnas}, {28'd0, col_drive((i / 4) % 4)});
            check("idle_held", {31'd0, key_held}, 32'd0);
            @(negedge clk);
        end

        // '0' at row 3, column 1: exact press and release timing.
        wait_col(1);
        keys[13] = 1'b1;
        exp_q.push_back(4'h0);
        repeat (11) @(negedge clk);
        check("lat_before", {31'd0, key_valid}, 32'd0);
        @(negedge clk);
        check("lat_at", {31'd0, key_valid}, 32'd1);
        repeat (28) @(negedge clk);
        check("hold_held", {31'd0, key_held}, 32'd1);
        check("hold_col", {28'd0, columnas}, 32'hD);
        keys = '0;
        repeat (10) @(negedge clk);
        check("rel_held_still", {31'd0, key_held}, 32'd1);
        check("rel_col_frozen", {28'd0, columnas}, 32'hD);
        @(negedge clk);
        check("rel_held_fall", {31'd0, key_held}, 32'd0);
        check("rel_next_col", {28'd0, columnas}, 32'hB);
        repeat (4) @(negedge clk);

        press_key(3, 2, 30, 4'hF);
        press_key(1, 1, 30, 4'h5);

        // Press bounce on 'B' (row 1, column 3): 3 low, 1 high, 20 low.
        wait_col(3);
        keys[7] = 1'b1;
        repeat (3) @(negedge clk);
        keys[7] = 1'b0;
        @(negedge clk);
        keys[7] = 1'b1;
        repeat (2) @(negedge clk);
        check("bounce_rescan_col", {28'd0, columnas}, 32'hE);
        check("bounce_held", {31'd0, key_held}, 32'd0);
        repeat (18) @(negedge clk);
        keys = '0;
        repeat (20) @(negedge clk);
        press_key(1, 3, 30, 4'hB);

        // Release bounce on '7' (row 2, column 0).
        wait_col(0);
        keys[8] = 1'b1;
        exp_q.push_back(4'h7);
        wait_held(1'b1);
        repeat (4) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            keys[8] = b[0];
            repeat (3) begin
                @(negedge clk);
                check("relbounce_held", {31'd0, key_held}, 32'd1);
            end
        end
        keys = '0;
        repeat (9) @(negedge clk);
        check("relbounce_held_still", {31'd0, key_held}, 32'd1);
        @(negedge clk);
        check("relbounce_held_fall", {31'd0, key_held}, 32'd0);
        repeat (4) @(negedge clk);

        // Rows 0 and 2 closed in column 3: row 0 wins.
        wait_col(3);
        keys[3]  = 1'b1;
        keys[11] = 1'b1;
        exp_q.push_back(4'hA);
        repeat (30) @(negedge clk);
        keys = '0;
        wait_held(1'b0);
        repeat (4) @(negedge clk);

        // Reset in the middle of debouncing '3' (row 0, column 2).
        wait_col(2);
        keys[2] = 1'b1;
        repeat (6) @(negedge clk);
        check("deb_col_frozen", {28'd0, columnas}, 32'hB);
        rst = 1'b0;
        #1;
        check("midrst_columnas", {28'd0, columnas}, 32'hE);
        check("midrst_key_code", {28'd0, key_code}, 32'h0);
        check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
        check("midrst_key_held", {31'd0, key_held}, 32'd0);
        keys = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_held", {31'd0, key_held}, 32'd0);

        check("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Front-end stage of the Booth calculator; drives the 4×4 matrix keypad and produces clean, debounced key events.
- Rotates an active-low column strobe, synchronises the row inputs, detects a press, debounces both press and release, and emits one single-cycle event per physical press.
- The calculator FSM consumes `key_code` on `key_valid` directly, with no further edge detection.

Parameters:
- SCAN_DIV, 27000: clk cycles each column stays driven (1 kHz per column at 27 MHz); must be ≥ 4.
- DEBOUNCE_CYC, 540000: consecutive stable cycles required to accept a press or a release (20 ms at 27 MHz); must be ≥ 1.

Ports:
- clk  input  1  system clock, 27 MHz
- rst  input  1  asynchronous, active-low reset
- columnas  output  4  column drive, active-low, exactly one bit low at all times
- filas  input  4  row sense, externally pulled up, low = key closed in the driven column; asynchronous
- key_code  output  4  code of the last accepted key
- key_valid  output  1  one-cycle pulse, new `key_code` accepted
- key_held  output  1  high from acceptance until release is debounced

Behaviour:
- Reset values (rst low, asynchronous):
  - `columnas` = 4'b1110, `key_code` = 4'h0, `key_valid` = 0, `key_held` = 0.
  - State is SCAN; scan counter, debounce counter and synchroniser flops are all cleared (synchroniser to 4'b1111).
- Reset mid-debounce or mid-hold aborts the operation with no event emitted.
- Row synchroniser:
  - `filas` passes through two flops (`rows_s`); all decisions use `rows_s`.
  - Synchroniser latency is 2 cycles.
- Key map, as (row, column) → code:
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: '*' = 4'hE, 0, '#' = 4'hF, D.
  - Columns are indexed 0..3 left to right; column c is driven when `columnas[c]` = 0.
- Scan counter:
  - Counts 0..SCAN_DIV-1 while in SCAN.
  - The last cycle of a slot is the sample cycle.
  - If no row is low on the sample cycle, the counter wraps to 0 and the column rotates c → (c+1) mod 4 (1110 → 1101 → 1011 → 0111 → 1110).
- FSM states and transitions:
  - SCAN, press detected: on a sample cycle with any `rows_s` bit low, capture column and row. If several rows are low, the lowest row index wins. Freeze `columnas`, clear the debounce counter, go to DEBOUNCE.
  - DEBOUNCE: `columnas` stays frozen.
    - Each cycle the captured row is low, the counter increments.
    - When the counter reaches DEBOUNCE_CYC: register `key_code` from the map, pulse `key_valid` for exactly 1 cycle (the following cycle), set `key_held` = 1, go to PRESSED.
    - If the captured row reads high before the count completes: no event, return to SCAN, resume at the next column with the scan counter = 0.
  - PRESSED: `columnas` stays frozen and `key_held` = 1. When the captured row reads high, clear the counter and go to RELEASE.
  - RELEASE:
    - Each cycle the captured row is high, the counter increments.
    - If the row reads low again, the counter clears and the state stays in RELEASE; no new event is emitted.
    - When the counter reaches DEBOUNCE_CYC: `key_held` = 0, return to SCAN at the next column with the scan counter = 0.
- Event rules:
  - `key_code` changes only in the cycle `key_valid` is high and otherwise holds its value.
  - At most one event per press; holding a key never repeats.
  - While DEBOUNCE/PRESSED/RELEASE is active, other keys (other columns, or other rows of the same column) are ignored.
- Press latency: `key_valid` rises DEBOUNCE_CYC+1 cycles after the detecting sample cycle (2 further cycles after the `filas` edge for the synchroniser).

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset, no keys → `columnas` cycles 1110, 1101, 1011, 0111, changing every 4 cycles; `key_valid` = 0 and `key_held` = 0 throughout.
- Hold row 3 low while column 1 is driven, for 40 cycles → exactly one `key_valid` pulse with `key_code` = 4'h0 on cycle T+9 after the sample cycle T; `key_held` = 1 until 8 cycles after release; `columnas` stays 1101 until then.
- Press '#' (row 3, column 2), then '5' (row 1, column 1), with clean release between → two pulses, `key_code` = 4'hF then 4'h5.
- Bounce: row low for 3 cycles, high for 1, then low for 20 → no pulse on the first glitch, return to SCAN; pulse appears only after a later clean 8-cycle low.
- Release bounce: in PRESSED, row toggles high/low every 3 cycles, then stays high → no second pulse; `key_held` falls 8 cycles after the final high begins.
- Rows 0 and 2 both low in column 3 → `key_code` = 4'hA. Separately, drive rst low mid-DEBOUNCE → outputs return to reset values immediately and no pulse is emitted.
